// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared types and constants for the UART control path
// Provides the TX scheduler FSM state enum, the legal prescale values,
// the REG2 field positions and a prescale legality helper.
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      POP       = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_e;

   localparam logic [5:0] PRESC_8  = 6'd8;
   localparam logic [5:0] PRESC_16 = 6'd16;
   localparam logic [5:0] PRESC_32 = 6'd32;

   localparam int REG2_PAR_EN_BIT  = 0;
   localparam int REG2_PAR_TYP_BIT = 1;
   localparam int REG2_PRESC_LSB   = 2;
   localparam int REG2_PRESC_MSB   = 7;

   function automatic logic presc_ok(input logic [5:0] p);
      return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser for an asynchronous input
// Ports: clk - destination clock; rst - async active-low reset;
//        i_d - asynchronous input; o_q - synchronised output (2-cycle delay).
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end

   assign o_q = r_q;

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: pops TX FIFO bytes, hands them to the transmitter, tracks Busy
// Ports: clk, rst (async active-low); F_EMPTY/RD_DATA/RD_INC - FWFT FIFO side;
//        Busy - async transmitter busy; REG2 - live config register;
//        TX_P_DATA/TX_DATA_VALID - transmitter data side;
//        PAR_EN/PAR_TYP/Prescale - config shadowed only while idle;
//        cfg_err - illegal REG2 prescale; tx_timeout - busy-ack timeout pulse;
//        frame_cnt - completed-frame counter, present only when the macro
//        UART_TX_FRAME_CNT_EN is defined.
module uart_tx_sched
   import uart_ctrl_pkg::*;
#(
   parameter int TO_W         = 8,
   parameter int BUSY_TIMEOUT = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        F_EMPTY,
   input  logic [7:0]  RD_DATA,
   output logic        RD_INC,
   input  logic        Busy,
   input  logic [7:0]  REG2,
   output logic [7:0]  TX_P_DATA,
   output logic        TX_DATA_VALID,
   output logic        PAR_EN,
   output logic        PAR_TYP,
   output logic [5:0]  Prescale,
   output logic        cfg_err,
`ifdef UART_TX_FRAME_CNT_EN
   output logic [15:0] frame_cnt,
`endif
   output logic        tx_timeout
);

   generate
      if (BUSY_TIMEOUT < 1 || BUSY_TIMEOUT > (1 << TO_W)) begin : g_bad_timeout
         $error("uart_tx_sched: BUSY_TIMEOUT must be in 1..2**TO_W");
      end
   endgenerate

   localparam logic [TO_W-1:0] CNT_LAST = TO_W'(BUSY_TIMEOUT - 1);

   tx_state_e       r_state;
   logic [TO_W-1:0] r_cnt;
   logic [7:0]      r_data;
   logic            r_valid;
   logic            r_par_en;
   logic            r_par_typ;
   logic [5:0]      r_presc;
   logic            r_timeout;
   logic            w_busy_s;
   logic            w_cfg_err;

   sync_2ff u_busy_sync (
      .clk (clk),
      .rst (rst),
      .i_d (Busy),
      .o_q (w_busy_s)
   );

   assign w_cfg_err = !presc_ok(REG2[REG2_PRESC_MSB:REG2_PRESC_LSB]);

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
         r_presc   <= PRESC_32;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         // shadow config only between frames so a frame never sees a change
         if (r_state == IDLE && !w_cfg_err) begin
            r_par_en  <= REG2[REG2_PAR_EN_BIT];
            r_par_typ <= REG2[REG2_PAR_TYP_BIT];
            r_presc   <= REG2[REG2_PRESC_MSB:REG2_PRESC_LSB];
         end
         case (r_state)
            IDLE: if (!F_EMPTY && !w_busy_s) r_state <= POP;
            POP: begin
               r_data  <= RD_DATA;
               r_valid <= 1'b1;
               r_cnt   <= '0;
               r_state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               r_cnt <= r_cnt + 1'b1;
               // busy ack wins over a timeout landing in the same cycle
               if (w_busy_s) begin
                  r_valid <= 1'b0;
                  r_state <= WAIT_DONE;
               end else if (r_cnt == CNT_LAST) begin
                  r_valid   <= 1'b0;
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            WAIT_DONE: if (!w_busy_s) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end

`ifdef UART_TX_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge clk or negedge rst)
      if (!rst) r_frame_cnt <= '0;
      else if (r_state == WAIT_DONE && !w_busy_s) r_frame_cnt <= r_frame_cnt + 16'd1;

   assign frame_cnt = r_frame_cnt;
`endif

   assign RD_INC        = (r_state == POP);
   assign TX_P_DATA     = r_data;
   assign TX_DATA_VALID = r_valid;
   assign PAR_EN        = r_par_en;
   assign PAR_TYP       = r_par_typ;
   assign Prescale      = r_presc;
   assign cfg_err       = w_cfg_err;
   assign tx_timeout    = r_timeout;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        F_EMPTY;
   logic [7:0]  RD_DATA;
   logic        RD_INC;
   logic        Busy;
   logic [7:0]  REG2 = 8'h83;
   logic [7:0]  TX_P_DATA;
   logic        TX_DATA_VALID;
   logic        PAR_EN;
   logic        PAR_TYP;
   logic [5:0]  Prescale;
   logic        cfg_err;
   logic        tx_timeout;
`ifdef UART_TX_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   uart_tx_sched #(.TO_W(8), .BUSY_TIMEOUT(10)) dut (
      .clk           (clk),
      .rst           (rst),
      .F_EMPTY       (F_EMPTY),
      .RD_DATA       (RD_DATA),
      .RD_INC        (RD_INC),
      .Busy          (Busy),
      .REG2          (REG2),
      .TX_P_DATA     (TX_P_DATA),
      .TX_DATA_VALID (TX_DATA_VALID),
      .PAR_EN        (PAR_EN),
      .PAR_TYP       (PAR_TYP),
      .Prescale      (Prescale),
      .cfg_err       (cfg_err),
`ifdef UART_TX_FRAME_CNT_EN
      .frame_cnt     (frame_cnt),
`endif
      .tx_timeout    (tx_timeout)
   );

   always #5 clk = ~clk;

   logic [7:0] fifo [0:63];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   assign F_EMPTY = (rd_ptr == wr_ptr);
   assign RD_DATA = fifo[rd_ptr[5:0]];
   always @(posedge clk) if (RD_INC) rd_ptr <= rd_ptr + 1;

   logic tx_en  = 1'b1;
   logic busy_m = 1'b0;
   logic busy_f = 1'b0;
   assign Busy = busy_m | busy_f;

   // transmitter model: Busy rises 3 cycles after valid, stays up 20 cycles
   initial forever begin
      @(negedge clk);
      if (tx_en && TX_DATA_VALID && !busy_m) begin
         repeat (3) @(posedge clk);
         #1 busy_m = 1'b1;
         repeat (20) @(posedge clk);
         #1 busy_m = 1'b0;
      end
   end

   int         rd_cnt = 0, n_log = 0, to_cnt = 0, viol = 0, run = 0, last_run = 0;
   logic [7:0] vlog [0:63];
   logic       prev_v = 1'b0, b1 = 1'b0, b2 = 1'b0;

   always @(posedge clk) begin
      b1 <= Busy;
      b2 <= b1;
   end

   always @(negedge clk) begin
      if (RD_INC) begin
         rd_cnt <= rd_cnt + 1;
         if (b2) viol <= viol + 1;
      end
      if (tx_timeout) to_cnt <= to_cnt + 1;
      if (TX_DATA_VALID && !prev_v) begin
         vlog[n_log[5:0]] <= TX_P_DATA;
         n_log <= n_log + 1;
      end
      run <= TX_DATA_VALID ? run + 1 : 0;
      if (!TX_DATA_VALID && prev_v) last_run <= run;
      prev_v <= TX_DATA_VALID;
   end

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      fifo[wr_ptr[5:0]] = b;
      wr_ptr++;
   endtask

   task automatic wait_busy();
      int k = 0;
      while (!Busy && k < 100) begin
         tick(1);
         k++;
      end
      chk("wait_busy", {31'd0, Busy}, 32'd1);
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!TX_DATA_VALID && k < 100) begin
         tick(1);
         k++;
      end
      chk("wait_valid", {31'd0, TX_DATA_VALID}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s_rd, s_log, s_to;
      tick(3);
      @(negedge clk);
      chk("rst_valid", {31'd0, TX_DATA_VALID}, 32'd0);
      chk("rst_rdinc", {31'd0, RD_INC}, 32'd0);
      chk("rst_data", {24'd0, TX_P_DATA}, 32'd0);
      chk("rst_presc", {26'd0, Prescale}, 32'd32);
      chk("rst_paren", {31'd0, PAR_EN}, 32'd0);
      chk("rst_partyp", {31'd0, PAR_TYP}, 32'd0);
      chk("rst_timeout", {31'd0, tx_timeout}, 32'd0);
      tick(1);
      rst = 1'b1;
      tick(2);
      chk("cfg_presc32", {26'd0, Prescale}, 32'd32);
      chk("cfg_paren", {31'd0, PAR_EN}, 32'd1);
      chk("cfg_partyp", {31'd0, PAR_TYP}, 32'd1);
      chk("cfg_err_ok", {31'd0, cfg_err}, 32'd0);

      s_rd = rd_cnt; s_log = n_log;
      push(8'hA5);
      tick(50);
      chk("basic_pops", rd_cnt - s_rd, 32'd1);
      chk("basic_data", {24'd0, vlog[s_log]}, 32'hA5);
      chk("basic_vlen", last_run, 32'd6);
      chk("basic_idle_valid", {31'd0, TX_DATA_VALID}, 32'd0);

      s_rd = rd_cnt; s_log = n_log;
      push(8'h01); push(8'h02); push(8'h03);
      tick(150);
      chk("burst_pops", rd_cnt - s_rd, 32'd3);
      chk("burst_d0", {24'd0, vlog[s_log]}, 32'h01);
      chk("burst_d1", {24'd0, vlog[s_log+1]}, 32'h02);
      chk("burst_d2", {24'd0, vlog[s_log+2]}, 32'h03);
      chk("burst_viol", viol, 32'd0);
      chk("burst_no_to", to_cnt, 32'd0);

      REG2 = 8'h40;
      tick(2);
      chk("mid_presc16", {26'd0, Prescale}, 32'd16);
      chk("mid_paren0", {31'd0, PAR_EN}, 32'd0);
      push(8'h11);
      wait_busy();
      REG2 = 8'h20;
      tick(3);
      chk("mid_hold16", {26'd0, Prescale}, 32'd16);
      chk("mid_cfg_ok", {31'd0, cfg_err}, 32'd0);
      tick(40);
      chk("mid_presc8", {26'd0, Prescale}, 32'd8);
      REG2 = 8'h30;
      #1;
      chk("bad_cfg_err", {31'd0, cfg_err}, 32'd1);
      tick(3);
      chk("bad_presc_hold", {26'd0, Prescale}, 32'd8);

      tx_en = 1'b0;
      s_rd = rd_cnt; s_log = n_log; s_to = to_cnt;
      push(8'h5A);
      tick(30);
      chk("to_pulses", to_cnt - s_to, 32'd1);
      chk("to_vlen", last_run, 32'd10);
      chk("to_data", {24'd0, vlog[s_log]}, 32'h5A);
      chk("to_pops", rd_cnt - s_rd, 32'd1);
      chk("to_valid_low", {31'd0, TX_DATA_VALID}, 32'd0);
      tx_en = 1'b1;
      s_log = n_log;
      push(8'h77);
      tick(50);
      chk("after_to_data", {24'd0, vlog[s_log]}, 32'h77);
      chk("after_to_vlen", last_run, 32'd6);
      chk("after_to_no_to", to_cnt - s_to, 32'd1);

      busy_f = 1'b1;
      tick(3);
      s_rd = rd_cnt; s_log = n_log;
      push(8'h66);
      tick(10);
      chk("busy_blocks", rd_cnt - s_rd, 32'd0);
      busy_f = 1'b0;
      tick(50);
      chk("busy_release", rd_cnt - s_rd, 32'd1);
      chk("busy_rel_data", {24'd0, vlog[s_log]}, 32'h66);

      tx_en = 1'b0;
      push(8'h3C);
      wait_valid();
      tick(2);
      rst = 1'b0;
      #1;
      chk("amid_valid", {31'd0, TX_DATA_VALID}, 32'd0);
      chk("amid_rdinc", {31'd0, RD_INC}, 32'd0);
      chk("amid_data", {24'd0, TX_P_DATA}, 32'd0);
      chk("amid_presc", {26'd0, Prescale}, 32'd32);
      chk("amid_paren", {31'd0, PAR_EN}, 32'd0);
      chk("amid_to", {31'd0, tx_timeout}, 32'd0);
      push(8'h99);
      tx_en = 1'b1;
      tick(2);
      rst = 1'b1;
      s_log = n_log;
      @(negedge clk);
      chk("rel_cyc1_rdinc", {31'd0, RD_INC}, 32'd0);
      @(negedge clk);
      chk("rel_cyc2_rdinc", {31'd0, RD_INC}, 32'd1);
      tick(50);
      chk("rel_data", {24'd0, vlog[s_log]}, 32'h99);

`ifdef UART_TX_FRAME_CNT_EN
      chk("fc_one", {16'd0, frame_cnt}, 32'd1);
      push(8'hA1); push(8'hA2); push(8'hA3);
      tick(150);
      tx_en = 1'b0;
      push(8'hB0);
      tick(30);
      tx_en = 1'b1;
      chk("fc_four", {16'd0, frame_cnt}, 32'd4);
      @(negedge clk);
      force dut.r_frame_cnt = 16'hFFFF;
      tick(1);
      release dut.r_frame_cnt;
      tick(1);
      chk("fc_preload", {16'd0, frame_cnt}, 32'hFFFF);
      push(8'hC0);
      tick(50);
      chk("fc_wrap", {16'd0, frame_cnt}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
